// File: rtl/spi_slave.sv
// SPI target oversampled on clk: supports all CPOL/CPHA modes, single-entry TX buffer
// with ready/load handshake, and a one-cycle rx_valid strobe per received word.
//   state | meaning
//   IDLE  | not selected; sclk edges ignored, mode tracked
//   SEL   | selected; sample/shift edges processed, miso driven
module spi_slave #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic              tx_underrun,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic {IDLE, SEL} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_s, cs_n_s, mosi_s;
    logic                   sclk_prev_q;
    logic [1:0]             mode_q;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]      rx_shreg_q, rx_shreg_d;
    logic [DATA_W-1:0]      rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic [DATA_W-1:0]      tx_shreg_q, tx_shreg_d;
    logic [DATA_W-1:0]      tx_buf_q, tx_buf_d;
    logic                   tx_ready_q, tx_ready_d;
    logic                   tx_underrun_q, tx_underrun_d;
    logic                   fresh_q, fresh_d;
    logic                   select, deselect, active;
    logic                   lead, trail, sample_edge, shift_edge;
    logic                   load_tx, accept;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_n_s = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            mode_q      <= 2'b00;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_prev_q <= sclk_s;
            if (cs_n_s) begin
                mode_q <= mode;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!cs_n_s) state_d = SEL;
            SEL:     if (cs_n_s)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        miso_oe = 1'b0;
        miso    = 1'b0;
        if (state_q == SEL) begin
            busy    = 1'b1;
            miso_oe = 1'b1;
            miso    = tx_shreg_q[DATA_W-1];
        end
    end

    assign select   = (state_q == IDLE) && !cs_n_s;
    assign deselect = (state_q == SEL) && cs_n_s;
    assign active   = (state_q == SEL) && !cs_n_s;
    assign lead     = active && (sclk_prev_q == mode_q[1]) && (sclk_s != mode_q[1]);
    assign trail    = active && (sclk_prev_q != mode_q[1]) && (sclk_s == mode_q[1]);
    assign sample_edge = mode_q[0] ? trail : lead;
    assign shift_edge  = mode_q[0] ? lead  : trail;

    // fresh_q marks a word loaded but not yet shifted, so the first CPHA=1 leading
    // edge after select presents it instead of consuming the buffer a second time.
    assign load_tx = select || (shift_edge && (bit_cnt_q == '0) && !fresh_q);
    assign accept  = tx_load && tx_ready_q;

    always_comb begin
        tx_shreg_d    = tx_shreg_q;
        tx_buf_d      = tx_buf_q;
        tx_ready_d    = tx_ready_q;
        tx_underrun_d = 1'b0;
        fresh_d       = fresh_q;
        if (load_tx) begin
            tx_shreg_d    = tx_ready_q ? '0 : tx_buf_q;
            tx_underrun_d = tx_ready_q;
            fresh_d       = 1'b1;
        end else if (shift_edge) begin
            fresh_d = 1'b0;
            if (bit_cnt_q != '0) begin
                tx_shreg_d = {tx_shreg_q[DATA_W-2:0], 1'b0};
            end
        end
        if (accept) begin
            tx_buf_d   = tx_data;
            tx_ready_d = 1'b0;
        end else if (load_tx) begin
            tx_ready_d = 1'b1;
        end
    end

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        rx_shreg_d = rx_shreg_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        if (select || deselect) begin
            bit_cnt_d = '0;
        end else if (sample_edge) begin
            rx_shreg_d = {rx_shreg_q[DATA_W-2:0], mosi_s};
            if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_d  = '0;
                rx_data_d  = {rx_shreg_q[DATA_W-2:0], mosi_s};
                rx_valid_d = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q     <= '0;
            rx_shreg_q    <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            tx_shreg_q    <= '0;
            tx_buf_q      <= '0;
            tx_ready_q    <= 1'b1;
            tx_underrun_q <= 1'b0;
            fresh_q       <= 1'b0;
        end else begin
            bit_cnt_q     <= bit_cnt_d;
            rx_shreg_q    <= rx_shreg_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            tx_shreg_q    <= tx_shreg_d;
            tx_buf_q      <= tx_buf_d;
            tx_ready_q    <= tx_ready_d;
            tx_underrun_q <= tx_underrun_d;
            fresh_q       <= fresh_d;
        end
    end

    assign tx_ready    = tx_ready_q;
    assign tx_underrun = tx_underrun_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a bench SPI master model drives sclk/cs_n/mosi and
// captures miso; expected bytes and pulse counts are hand-computed constants.
module tb_spi_slave;
    localparam int HP = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] mode;
    logic       sclk, cs_n, mosi;
    logic       miso, miso_oe;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_ready, tx_underrun;
    logic [7:0] rx_data;
    logic       rx_valid, busy;

    int checks = 0;
    int errors = 0;
    int rxv_cnt = 0;
    int unr_cnt = 0;

    spi_slave #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_load(tx_load),
        .tx_ready(tx_ready), .tx_underrun(tx_underrun), .rx_data(rx_data),
        .rx_valid(rx_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rx_valid === 1'b1) rxv_cnt++;
        if (tx_underrun === 1'b1) unr_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_byte(input logic [7:0] b);
        tx_data = b;
        tx_load = 1'b1;
        cyc(1);
        tx_load = 1'b0;
    endtask

    // Bench SPI master: nbits MSB-first from tx[nbits-1:0], captured miso in rx.
    task automatic spi_xfer(input logic [1:0] m, input int nbits, input logic [15:0] tx,
                            output logic [15:0] rx, output logic oe_mid);
        logic cpol, cpha;
        cpol   = m[1];
        cpha   = m[0];
        rx     = '0;
        oe_mid = 1'b0;
        mode   = m;
        sclk   = cpol;
        cs_n   = 1'b1;
        cyc(6);
        cs_n = 1'b0;
        if (!cpha) mosi = tx[nbits-1];
        cyc(HP);
        for (int i = nbits - 1; i >= 0; i--) begin
            sclk = ~cpol;
            if (cpha) mosi = tx[i];
            else      rx = {rx[14:0], miso};
            if (i == nbits / 2) oe_mid = miso_oe;
            cyc(HP);
            sclk = cpol;
            if (cpha)       rx = {rx[14:0], miso};
            else if (i > 0) mosi = tx[i-1];
            cyc(HP);
        end
        cs_n = 1'b1;
        cyc(6);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mode = 2'b00; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        tx_data = 8'h00; tx_load = 1'b0;
        cyc(3);
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso got %b exp 0", miso); end
        checks++; if (miso_oe !== 1'b0) begin errors++; $display("FAIL reset_miso_oe got %b exp 0", miso_oe); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready got %b exp 1", tx_ready); end
        checks++; if (tx_underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b exp 0", tx_underrun); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h exp 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b exp 0", rx_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        rst_n = 1'b1;
        cyc(4);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b exp 0", busy); end
    endtask

    task automatic test_mode0();
        logic [15:0] r;
        logic oe;
        int v0;
        load_byte(8'hA5);
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL m0_ready_after_load got %b exp 0", tx_ready); end
        v0 = rxv_cnt;
        spi_xfer(2'b00, 8, 16'h003C, r, oe);
        checks++; if (r[7:0] !== 8'hA5) begin errors++; $display("FAIL m0_master_rx got %h exp a5", r[7:0]); end
        checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL m0_rx_data got %h exp 3c", rx_data); end
        checks++; if (rxv_cnt - v0 !== 1) begin errors++; $display("FAIL m0_rx_valid_pulses got %0d exp 1", rxv_cnt - v0); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL m0_tx_ready got %b exp 1", tx_ready); end
        checks++; if (oe !== 1'b1) begin errors++; $display("FAIL m0_oe_mid got %b exp 1", oe); end
    endtask

    task automatic test_modes();
        logic [15:0] r;
        logic oe;
        int v0;
        for (int m = 1; m < 4; m++) begin
            load_byte(8'h81);
            v0 = rxv_cnt;
            spi_xfer(2'(m), 8, 16'h007E, r, oe);
            checks++; if (r[7:0] !== 8'h81) begin errors++; $display("FAIL mode%0d_master_rx got %h exp 81", m, r[7:0]); end
            checks++; if (rx_data !== 8'h7E) begin errors++; $display("FAIL mode%0d_rx_data got %h exp 7e", m, rx_data); end
            checks++; if (rxv_cnt - v0 !== 1) begin errors++; $display("FAIL mode%0d_rx_valid_pulses got %0d exp 1", m, rxv_cnt - v0); end
            checks++; if (oe !== 1'b1) begin errors++; $display("FAIL mode%0d_oe_selected got %b exp 1", m, oe); end
            checks++; if (miso_oe !== 1'b0) begin errors++; $display("FAIL mode%0d_oe_deselected got %b exp 0", m, miso_oe); end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] r;
        logic oe;
        logic got;
        int v0, u0;
        got = 1'b0;
        load_byte(8'h12);
        v0 = rxv_cnt;
        u0 = unr_cnt;
        fork
            spi_xfer(2'b01, 16, 16'hBEEF, r, oe);
            begin
                for (int i = 0; i < 200 && !got; i++) begin
                    cyc(1);
                    if (tx_ready === 1'b1) got = 1'b1;
                end
                if (got) load_byte(8'h34);
            end
        join
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL b2b_ready_wait got %b exp 1", got); end
        checks++; if (r !== 16'h1234) begin errors++; $display("FAIL b2b_master_rx got %h exp 1234", r); end
        checks++; if (rxv_cnt - v0 !== 2) begin errors++; $display("FAIL b2b_rx_valid_pulses got %0d exp 2", rxv_cnt - v0); end
        checks++; if (rx_data !== 8'hEF) begin errors++; $display("FAIL b2b_rx_data got %h exp ef", rx_data); end
        checks++; if (unr_cnt - u0 !== 0) begin errors++; $display("FAIL b2b_underruns got %0d exp 0", unr_cnt - u0); end
    endtask

    task automatic test_underrun();
        logic [15:0] r;
        logic oe;
        int u0;
        u0 = unr_cnt;
        spi_xfer(2'b01, 8, 16'h005A, r, oe);
        checks++; if (r[7:0] !== 8'h00) begin errors++; $display("FAIL unr_master_rx got %h exp 00", r[7:0]); end
        checks++; if (unr_cnt - u0 !== 1) begin errors++; $display("FAIL unr_pulses got %0d exp 1", unr_cnt - u0); end
        checks++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL unr_rx_data got %h exp 5a", rx_data); end
    endtask

    task automatic test_abort();
        logic [15:0] r;
        logic oe;
        int v0;
        v0 = rxv_cnt;
        spi_xfer(2'b00, 3, 16'h0007, r, oe);
        checks++; if (rxv_cnt - v0 !== 0) begin errors++; $display("FAIL abort_rx_valid got %0d exp 0", rxv_cnt - v0); end
        checks++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL abort_rx_data_held got %h exp 5a", rx_data); end
        load_byte(8'h99);
        v0 = rxv_cnt;
        spi_xfer(2'b00, 8, 16'h0055, r, oe);
        checks++; if (rx_data !== 8'h55) begin errors++; $display("FAIL abort_next_rx_data got %h exp 55", rx_data); end
        checks++; if (r[7:0] !== 8'h99) begin errors++; $display("FAIL abort_next_master_rx got %h exp 99", r[7:0]); end
        checks++; if (rxv_cnt - v0 !== 1) begin errors++; $display("FAIL abort_next_rx_valid got %0d exp 1", rxv_cnt - v0); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] r;
        logic oe;
        logic busy_before;
        int v0;
        busy_before = 1'b0;
        v0 = rxv_cnt;
        fork
            spi_xfer(2'b00, 8, 16'h00F0, r, oe);
            begin
                cyc(40);
                busy_before = busy;
                rst_n = 1'b0;
                #2;
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
                checks++; if (miso_oe !== 1'b0) begin errors++; $display("FAIL rstmid_miso_oe got %b exp 0", miso_oe); end
                checks++; if (miso !== 1'b0) begin errors++; $display("FAIL rstmid_miso got %b exp 0", miso); end
                checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_rx_data got %h exp 00", rx_data); end
                checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rstmid_tx_ready got %b exp 1", tx_ready); end
            end
        join
        checks++; if (busy_before !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got %b exp 1", busy_before); end
        checks++; if (rxv_cnt - v0 !== 0) begin errors++; $display("FAIL rstmid_rx_valid got %0d exp 0", rxv_cnt - v0); end
        rst_n = 1'b1;
        cyc(4);
        load_byte(8'h3C);
        v0 = rxv_cnt;
        spi_xfer(2'b11, 8, 16'h00C3, r, oe);
        checks++; if (r[7:0] !== 8'h3C) begin errors++; $display("FAIL rstmid_after_master_rx got %h exp 3c", r[7:0]); end
        checks++; if (rx_data !== 8'hC3) begin errors++; $display("FAIL rstmid_after_rx_data got %h exp c3", rx_data); end
        checks++; if (rxv_cnt - v0 !== 1) begin errors++; $display("FAIL rstmid_after_rx_valid got %0d exp 1", rxv_cnt - v0); end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_modes();
        test_back_to_back();
        test_underrun();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
